// File: rtl/dual_bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// dual_bin_to_bcd_pkg
// Shared constants, FSM state type and the BCD nibble adjust helper used by
// the dual binary-to-BCD converter and its per-lane datapath.
// -----------------------------------------------------------------------------
package dual_bin_to_bcd_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned MAX_DEC    = 99;
   localparam int unsigned BCD_ADJ_TH = 5;
   localparam int unsigned BCD_ADJ    = 3;

   // Two BCD digits per lane; inputs are clamped to 99, so no hundreds digit.
   localparam int unsigned SCRATCH_W  = 2 * DIGIT_W;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Double-dabble correction: a nibble of 5 or more gets 3 added before the
   // shift so that the doubled value carries correctly into the next digit.
   function automatic logic [DIGIT_W-1:0] bcd_adjust(input logic [DIGIT_W-1:0] nib);
      if (nib >= DIGIT_W'(BCD_ADJ_TH)) begin
         return nib + DIGIT_W'(BCD_ADJ);
      end
      return nib;
   endfunction

endpackage

// File: rtl/dual_bin_to_bcd_lane.sv
// -----------------------------------------------------------------------------
// bcd_lane
// One conversion lane: binary shift register, 8-bit BCD scratch and the
// combinational add-3/shift step.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture bin_in and clear the scratch
//   shift_en   : perform one add-3/shift step
//   bin_in     : clamped binary value (0..99)
//   bcd_next   : scratch value after the current step (tens:ones); on the
//                final step this is the finished two-digit result
// -----------------------------------------------------------------------------
module bcd_lane
   import dual_bin_to_bcd_pkg::*;
#(
   parameter int unsigned BIN_W = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift_en,
   input  logic [BIN_W-1:0]     bin_in,
   output logic [SCRATCH_W-1:0] bcd_next
);

   logic [BIN_W-1:0]           bin_q;
   logic [BIN_W-1:0]           bin_next;
   logic [SCRATCH_W-1:0]       bcd_q;
   logic [SCRATCH_W-1:0]       adj;
   logic [SCRATCH_W+BIN_W-1:0] shifted;

   always_comb begin
      adj      = {bcd_adjust(bcd_q[SCRATCH_W-1:DIGIT_W]), bcd_adjust(bcd_q[DIGIT_W-1:0])};
      shifted  = {adj, bin_q} << 1;
      bcd_next = shifted[SCRATCH_W+BIN_W-1:BIN_W];
      bin_next = shifted[BIN_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else if (load) begin
         bin_q <= bin_in;
         bcd_q <= '0;
      end else if (shift_en) begin
         bin_q <= bin_next;
         bcd_q <= bcd_next;
      end
   end

endmodule

// File: rtl/dual_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// dual_bin_to_bcd
// Converts two binary values (left/right, clamped to 0..99) into four
// registered BCD digits for the seven-segment digit mux. Both lanes run the
// double-dabble algorithm in parallel, one bit per clock, BIN_W clocks per
// conversion. Digit outputs only change on the final shift edge.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   start                   : conversion request, sampled only in IDLE
//   left_bin, right_bin     : binary inputs, captured on the accepting edge
//   busy                    : conversion in progress
//   done                    : one-cycle pulse when new digits are valid
//   left_ONES/left_TENS     : left lane BCD digits
//   right_ONES/right_TENS   : right lane BCD digits
//   left_sat, right_sat     : last converted input exceeded 99 and was clamped
//
// BIN_W must be at least 7 so that 99 is representable.
// -----------------------------------------------------------------------------
module dual_bin_to_bcd
   import dual_bin_to_bcd_pkg::*;
#(
   parameter int unsigned BIN_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BIN_W-1:0]   left_bin,
   input  logic [BIN_W-1:0]   right_bin,
   output logic               busy,
   output logic               done,
   output logic [DIGIT_W-1:0] left_ONES,
   output logic [DIGIT_W-1:0] left_TENS,
   output logic [DIGIT_W-1:0] right_ONES,
   output logic [DIGIT_W-1:0] right_TENS,
   output logic               left_sat,
   output logic               right_sat
);

   localparam int unsigned      CNT_W    = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_DEC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   state_t               state_q;
   state_t               state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 load;
   logic                 shift_en;
   logic                 last_shift;

   logic                 left_over;
   logic                 right_over;
   logic [BIN_W-1:0]     left_clamp;
   logic [BIN_W-1:0]     right_clamp;
   logic                 left_sat_q;
   logic                 right_sat_q;

   logic [SCRATCH_W-1:0] left_bcd;
   logic [SCRATCH_W-1:0] right_bcd;

   // Saturation detect and clamp ahead of the lane shift registers.
   always_comb begin
      left_over   = (left_bin  > MAX_BIN);
      right_over  = (right_bin > MAX_BIN);
      left_clamp  = left_over  ? MAX_BIN : left_bin;
      right_clamp = right_over ? MAX_BIN : right_bin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      shift_en   = 1'b0;
      last_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt_q == LAST_CNT) begin
               last_shift = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         left_sat_q  <= 1'b0;
         right_sat_q <= 1'b0;
      end else if (load) begin
         cnt_q       <= '0;
         left_sat_q  <= left_over;
         right_sat_q <= right_over;
      end else if (shift_en) begin
         cnt_q <= last_shift ? '0 : cnt_q + CNT_W'(1);
      end
   end

   bcd_lane #(.BIN_W(BIN_W)) u_left_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .bin_in   (left_clamp),
      .bcd_next (left_bcd)
   );

   bcd_lane #(.BIN_W(BIN_W)) u_right_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .bin_in   (right_clamp),
      .bcd_next (right_bcd)
   );

   // The lanes' next-step values are taken on the last shift so the outputs
   // land on the same edge as the final shift rather than one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done       <= 1'b0;
         left_ONES  <= '0;
         left_TENS  <= '0;
         right_ONES <= '0;
         right_TENS <= '0;
         left_sat   <= 1'b0;
         right_sat  <= 1'b0;
      end else begin
         done <= last_shift;
         if (last_shift) begin
            left_TENS  <= left_bcd[SCRATCH_W-1:DIGIT_W];
            left_ONES  <= left_bcd[DIGIT_W-1:0];
            right_TENS <= right_bcd[SCRATCH_W-1:DIGIT_W];
            right_ONES <= right_bcd[DIGIT_W-1:0];
            left_sat   <= left_sat_q;
            right_sat  <= right_sat_q;
         end
      end
   end

endmodule

// File: tb/tb_dual_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_dual_bin_to_bcd
// Scoreboard bench for dual_bin_to_bcd. The stimulus process decides which
// edges accept a request, computes the expected digits with plain decimal
// arithmetic and queues them with the edge on which they must appear. A
// separate monitor on the falling edge checks busy, done, result values and
// that the digits hold their previous value between results.
// -----------------------------------------------------------------------------
module tb_dual_bin_to_bcd;

   localparam int unsigned BIN_W = 7;
   localparam int unsigned MAXV  = 99;
   localparam int unsigned TOPV  = (1 << BIN_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [BIN_W-1:0] left_bin = '0;
   logic [BIN_W-1:0] right_bin = '0;
   logic             busy;
   logic             done;
   logic [3:0]       left_ONES;
   logic [3:0]       left_TENS;
   logic [3:0]       right_ONES;
   logic [3:0]       right_TENS;
   logic             left_sat;
   logic             right_sat;

   dual_bin_to_bcd #(.BIN_W(BIN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .left_bin   (left_bin),
      .right_bin  (right_bin),
      .busy       (busy),
      .done       (done),
      .left_ONES  (left_ONES),
      .left_TENS  (left_TENS),
      .right_ONES (right_ONES),
      .right_TENS (right_TENS),
      .left_sat   (left_sat),
      .right_sat  (right_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] res;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned edge_n = 0;
   int unsigned rem    = 0;
   logic        model_busy = 1'b0;
   logic [17:0] held = '0;
   bit          mon_en = 1'b0;

   // Packed as {left_TENS, left_ONES, right_TENS, right_ONES, left_sat, right_sat}.
   function automatic logic [17:0] ref_result(input int unsigned l, input int unsigned r);
      int unsigned lv;
      int unsigned rv;
      lv = (l > MAXV) ? MAXV : l;
      rv = (r > MAXV) ? MAXV : r;
      return {4'(lv / 10), 4'(lv % 10), 4'(rv / 10), 4'(rv % 10), 1'(l > MAXV), 1'(r > MAXV)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
      end
   endtask

   // Drive one cycle of inputs, let the DUT take the edge, then advance the
   // model: a request is accepted only when no conversion is outstanding.
   task automatic step(input bit s, input int unsigned l, input int unsigned r);
      start     = s;
      left_bin  = BIN_W'(l);
      right_bin = BIN_W'(r);
      @(posedge clk);
      #1;
      edge_n++;
      if (!rst) begin
         if (rem > 0) begin
            rem--;
         end else if (s) begin
            sb.push_back('{res: ref_result(l, r), due: edge_n + BIN_W});
            rem = BIN_W;
         end
      end
      model_busy = (rem > 0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         step(1'b0, $urandom_range(0, TOPV), $urandom_range(0, TOPV));
      end
   endtask

   task automatic convert(input int unsigned l, input int unsigned r);
      step(1'b1, l, r);
      idle(BIN_W + 2);
   endtask

   // Falling-edge monitor.
   initial begin : monitor
      logic [17:0] dut_res;
      bit          exp_done;
      exp_t        e;
      wait (mon_en);
      forever begin
         @(negedge clk);
         dut_res  = {left_TENS, left_ONES, right_TENS, right_ONES, left_sat, right_sat};
         exp_done = (sb.size() > 0) && (sb[0].due == edge_n);
         chk("busy", 32'(busy), 32'(model_busy));
         if (done || exp_done) begin
            chk("done", 32'(done), 32'(exp_done));
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("done_edge", edge_n, e.due);
               chk("result", 32'(dut_res), 32'(e.res));
               held = e.res;
            end
         end else begin
            chk("hold", 32'(dut_res), 32'(held));
         end
      end
   end

   initial begin : stim
      #1 rst = 1'b1;
      #1 mon_en = 1'b1;
      idle(3);
      chk("reset_digits", 32'({left_TENS, left_ONES, right_TENS, right_ONES, left_sat, right_sat}), 32'h0);
      chk("reset_busy_done", 32'({busy, done}), 32'h0);
      rst = 1'b0;
      idle(2);

      // Directed values, including clamping and the 99/0 boundaries.
      convert(42, 7);
      convert(127, 100);
      convert(99, 0);
      convert(100, 99);

      // Start held high with inputs changing every cycle.
      for (int unsigned i = 0; i < 40; i++) begin
         step(1'b1, $urandom_range(0, TOPV), $urandom_range(0, TOPV));
      end
      idle(BIN_W + 2);

      // Extra start pulses mid-conversion must be ignored.
      step(1'b1, 60, 31);
      for (int unsigned c = 1; c <= BIN_W + 2; c++) begin
         step((c == 2) || (c == 5), $urandom_range(0, TOPV), $urandom_range(0, TOPV));
      end

      // Reset during cycle 4 of a conversion: digits clear at once, no done.
      step(1'b1, 88, 55);
      for (int unsigned c = 1; c < 4; c++) begin
         step(1'b0, 88, 55);
      end
      #1 rst = 1'b1;
      sb.delete();
      rem        = 0;
      model_busy = 1'b0;
      held       = '0;
      #1;
      chk("midrst_digits", 32'({left_TENS, left_ONES, right_TENS, right_ONES, left_sat, right_sat}), 32'h0);
      chk("midrst_busy_done", 32'({busy, done}), 32'h0);
      idle(2);
      rst = 1'b0;
      idle(BIN_W + 2);
      convert(88, 55);

      // Randomized requests with random gaps and stray start pulses.
      for (int unsigned n = 0; n < 30; n++) begin
         step(1'b1, $urandom_range(0, TOPV), $urandom_range(0, TOPV));
         for (int unsigned g = $urandom_range(4, 10); g > 0; g--) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, TOPV), $urandom_range(0, TOPV));
         end
      end

      idle(BIN_W + 4);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
